// File: rtl/usb_line_dir_ctrl_pkg.sv
//------------------------------------------------------------------------------
// usb_line_dir_ctrl_pkg : line-state constants and direction-FSM state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package usb_line_dir_ctrl_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_RX_GAP    = 3'd2,
    ST_TX        = 3'd3,
    ST_TX_GAP    = 3'd4,
    ST_WAIT_RESP = 3'd5
  } dir_state_e;

  // States in which the receive path may accept a packet
  function automatic logic rx_side(input dir_state_e s);
    return (s == ST_IDLE) || (s == ST_RX) || (s == ST_RX_GAP) || (s == ST_WAIT_RESP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_line_dir_ctrl_if.sv
//------------------------------------------------------------------------------
// usb_line_dir_ctrl_if : PHY RX / TX serializer / link signals of the direction controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface usb_line_dir_ctrl_if;
  logic [1:0] line_state;
  logic       rx_in_packet;
  logic       rx_packet_done;
  logic       rx_error;
  logic       tx_req;
  logic       tx_done;
  logic       expect_resp;
  logic       rx_enable;
  logic       tx_grant;
  logic       line_oe;
  logic       busy;
  logic       resp_timeout;

  modport slave (
    input  line_state, rx_in_packet, rx_packet_done, rx_error,
           tx_req, tx_done, expect_resp,
    output rx_enable, tx_grant, line_oe, busy, resp_timeout
  );

  modport master (
    output line_state, rx_in_packet, rx_packet_done, rx_error,
           tx_req, tx_done, expect_resp,
    input  rx_enable, tx_grant, line_oe, busy, resp_timeout
  );
endinterface

`default_nettype wire

// File: rtl/usb_line_dir_ctrl_timer.sv
//------------------------------------------------------------------------------
// usb_line_dir_ctrl_timer : loadable down-counter, saturating at zero
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module usb_line_dir_ctrl_timer #(
  parameter int WIDTH = 5
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             en,
  output logic                  zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (load)
      r_count <= load_val;
    else if (en && (r_count != '0))
      r_count <= r_count - 1'b1;
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/usb_line_dir_ctrl.sv
//------------------------------------------------------------------------------
// usb_line_dir_ctrl : half-duplex USB line ownership and inter-packet gap control
// Optional: USB_RESP_TIMEOUT_EN adds the response-timeout wait state.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module usb_line_dir_ctrl
  import usb_line_dir_ctrl_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 18
) (
  input wire logic           clk,
  input wire logic           reset,
  usb_line_dir_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  dir_state_e      r_state, w_next;
  logic            w_timer_load, w_timer_en, w_timer_zero;
  logic [CW-1:0]   w_timer_val;
  logic            w_resp_to;
  logic            r_rx_enable, r_tx_grant, r_line_oe, r_busy, r_resp_timeout;

`ifdef USB_RESP_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  logic r_expect_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_expect_resp <= 1'b0;
    else if ((r_state == ST_TX) && bus.tx_done)
      r_expect_resp <= bus.expect_resp;
  end
`else
  logic unused_expect_resp;
  assign unused_expect_resp = bus.expect_resp;
`endif

  usb_line_dir_ctrl_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_timer_load),
    .load_val (w_timer_val),
    .en       (w_timer_en),
    .zero     (w_timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    w_timer_val  = '0;
    w_timer_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A starting receive always beats a pending transmit request
        if (bus.rx_in_packet)
          w_next = ST_RX;
        else if (bus.tx_req && (bus.line_state == LS_J))
          w_next = ST_TX;
      end
      ST_RX: begin
        if (bus.rx_packet_done || bus.rx_error) begin
          w_next       = ST_RX_GAP;
          w_timer_load = 1'b1;
          w_timer_val  = GAP_LOAD;
        end
      end
      ST_RX_GAP: begin
        if (bus.rx_in_packet)
          w_next = ST_RX;
        else if (w_timer_zero)
          w_next = ST_IDLE;
        else
          w_timer_en = 1'b1;
      end
      ST_TX: begin
        if (bus.tx_done) begin
          w_next       = ST_TX_GAP;
          w_timer_load = 1'b1;
          w_timer_val  = GAP_LOAD;
        end
      end
      ST_TX_GAP: begin
        if (w_timer_zero) begin
`ifdef USB_RESP_TIMEOUT_EN
          if (r_expect_resp) begin
            w_next       = ST_WAIT_RESP;
            w_timer_load = 1'b1;
            w_timer_val  = TIMEOUT_LOAD;
          end else begin
            w_next = ST_IDLE;
          end
`else
          w_next = ST_IDLE;
`endif
        end else begin
          w_timer_en = 1'b1;
        end
      end
`ifdef USB_RESP_TIMEOUT_EN
      ST_WAIT_RESP: begin
        if (bus.rx_in_packet) begin
          w_next       = ST_RX;
          w_timer_load = 1'b1;
        end else if (w_timer_zero) begin
          w_next = ST_IDLE;
        end else begin
          w_timer_en = 1'b1;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef USB_RESP_TIMEOUT_EN
  assign w_resp_to = (r_state == ST_WAIT_RESP) && (w_next == ST_IDLE);
`else
  assign w_resp_to = 1'b0;
`endif

  // Outputs are decoded from the next state so they settle one edge after the decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_enable    <= 1'b1;
      r_tx_grant     <= 1'b0;
      r_line_oe      <= 1'b0;
      r_busy         <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_rx_enable    <= rx_side(w_next);
      r_tx_grant     <= (w_next == ST_TX);
      r_line_oe      <= (w_next == ST_TX);
      r_busy         <= (w_next != ST_IDLE);
      r_resp_timeout <= w_resp_to;
    end
  end

  assign bus.rx_enable    = r_rx_enable;
  assign bus.tx_grant     = r_tx_grant;
  assign bus.line_oe      = r_line_oe;
  assign bus.busy         = r_busy;
  assign bus.resp_timeout = r_resp_timeout;

endmodule

`default_nettype wire

// File: tb/tb_usb_line_dir_ctrl.sv
//------------------------------------------------------------------------------
// tb_usb_line_dir_ctrl : directed vectors with a queued scoreboard for usb_line_dir_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_usb_line_dir_ctrl;
  import usb_line_dir_ctrl_pkg::*;

  // Output vector order: {rx_enable, tx_grant, line_oe, busy, resp_timeout}
  localparam logic [4:0] O_IDLE = 5'b10000;
  localparam logic [4:0] O_RX   = 5'b10010;
  localparam logic [4:0] O_TX   = 5'b01110;
  localparam logic [4:0] O_TXG  = 5'b00010;
  localparam logic [4:0] O_WAIT = 5'b10010;
  localparam logic [4:0] O_TO   = 5'b10001;

  typedef struct {
    int         id;
    logic [4:0] outs;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t sb_q[$];

  usb_line_dir_ctrl_if bus();

  usb_line_dir_ctrl #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] dut_outs();
    return {bus.rx_enable, bus.tx_grant, bus.line_oe, bus.busy, bus.resp_timeout};
  endfunction

  // Monitor: one registered output vector per clock edge is compared against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (dut_outs() !== e.outs) begin
          failures++;
          $display("FAIL step%0d outputs got=%b want=%b", e.id, dut_outs(), e.outs);
        end
      end
    end
  end

  task automatic step(input logic [1:0] ls, input logic rip, input logic rpd, input logic rerr,
                      input logic treq, input logic tdone, input logic er, input logic [4:0] want);
    exp_t e;
    @(negedge clk);
    bus.line_state     = ls;
    bus.rx_in_packet   = rip;
    bus.rx_packet_done = rpd;
    bus.rx_error       = rerr;
    bus.tx_req         = treq;
    bus.tx_done        = tdone;
    bus.expect_resp    = er;
    step_no++;
    e.id   = step_no;
    e.outs = want;
    sb_q.push_back(e);
  endtask

  task automatic direct_check(input string name, input logic [4:0] want);
    checks++;
    if (dut_outs() !== want) begin
      failures++;
      $display("FAIL %s outputs got=%b want=%b", name, dut_outs(), want);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.line_state     = LS_J;
    bus.rx_in_packet   = 1'b0;
    bus.rx_packet_done = 1'b0;
    bus.rx_error       = 1'b0;
    bus.tx_req         = 1'b0;
    bus.tx_done        = 1'b0;
    bus.expect_resp    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    direct_check("reset_state", O_IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Grant on J, then gap after tx_done with the request still held
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);
    step(LS_J, 0, 0, 0, 1, 1, 0, O_TXG);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TXG);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_IDLE);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);
    step(LS_J, 0, 0, 0, 0, 1, 0, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);
    // Stray pulses outside their states
    step(LS_J, 0, 0, 0, 0, 1, 0, O_IDLE);
    step(LS_J, 0, 1, 0, 0, 0, 0, O_IDLE);
    step(LS_J, 0, 0, 1, 0, 0, 0, O_IDLE);

    // RX wins against a simultaneous tx_req; grant only after the RX gap
    step(LS_J, 1, 0, 0, 1, 0, 0, O_RX);
    step(LS_J, 1, 0, 0, 1, 0, 0, O_RX);
    step(LS_J, 0, 1, 0, 1, 0, 0, O_RX);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_RX);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_IDLE);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);
    step(LS_J, 0, 0, 0, 0, 1, 0, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);

    // rx_error closes a packet; back-to-back RX from the gap
    step(LS_J, 1, 0, 0, 0, 0, 0, O_RX);
    step(LS_J, 0, 0, 1, 0, 0, 0, O_RX);
    step(LS_J, 1, 0, 0, 0, 0, 0, O_RX);
    step(LS_J, 0, 1, 0, 0, 0, 0, O_RX);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_RX);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);

    // No grant unless the line is idle J
    step(LS_SE0, 0, 0, 0, 1, 0, 0, O_IDLE);
    step(LS_K,   0, 0, 0, 1, 0, 0, O_IDLE);
    step(2'b11,  0, 0, 0, 1, 0, 0, O_IDLE);
    step(LS_J,   0, 0, 0, 1, 0, 0, O_TX);
    // RX inputs ignored while transmitting
    step(LS_J,   1, 0, 0, 0, 0, 0, O_TX);
    step(LS_J,   0, 1, 0, 0, 0, 0, O_TX);
    step(LS_J,   0, 0, 1, 0, 0, 0, O_TX);

    // tx_done with expect_resp=1
    step(LS_J, 0, 0, 0, 0, 1, 1, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_TXG);
`ifdef USB_RESP_TIMEOUT_EN
    step(LS_J, 0, 0, 0, 0, 0, 0, O_WAIT);
    for (int k = 0; k < 17; k++)
      step(LS_J, 0, 0, 0, (k < 5), 0, 0, O_WAIT);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_TO);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);
    // Response arrives on the 10th cycle of the wait: no timeout
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);
    step(LS_J, 0, 0, 0, 0, 1, 1, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_TXG);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_WAIT);
    for (int k = 0; k < 9; k++)
      step(LS_J, 0, 0, 0, 0, 0, 0, O_WAIT);
    step(LS_J, 1, 0, 0, 0, 0, 0, O_RX);
    step(LS_J, 1, 0, 0, 0, 0, 0, O_RX);
    step(LS_J, 0, 1, 0, 0, 0, 0, O_RX);
    step(LS_J, 0, 0, 0, 0, 0, 0, O_RX);
    for (int k = 0; k < 12; k++)
      step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);
`else
    step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);
    for (int k = 0; k < 20; k++)
      step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);
`endif

    // Asynchronous reset in the middle of a transmit
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    direct_check("async_reset_mid_tx", O_IDLE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.tx_req = 1'b0;
    step(LS_J, 0, 0, 0, 0, 0, 0, O_IDLE);
    step(LS_J, 0, 0, 0, 1, 0, 0, O_TX);

    for (int k = 0; k < 5 && sb_q.size() > 0; k++)
      @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
